// File: rtl/line_buf_sched.sv
// Sequencer for the ring of WIN_SIZE+1 line buffers feeding the sliding-window datapath:
// tracks write/read pointers and occupancy, issues window pops, line flushes and frame close-out.
module line_buf_sched #(
  parameter int WIN_SIZE   = 5,
  parameter int LINE_CNT_W = 11
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          sof_i,
  input  logic                          wr_eol_i,
  input  logic                          rd_eol_i,
  input  logic [WIN_SIZE:0]             buf_unread_i,
  input  logic [LINE_CNT_W-1:0]         frame_lines_i,
  output logic [WIN_SIZE:0]             wr_sel_o,
  output logic                          wr_stall_o,
  output logic [$clog2(WIN_SIZE+1)-1:0] rd_base_o,
  output logic                          rd_start_o,
  output logic [WIN_SIZE:0]             flush_o,
  output logic                          frame_done_o,
  output logic [1:0]                    state_o
);

  localparam int NBUF  = WIN_SIZE + 1;
  localparam int PTR_W = $clog2(NBUF);
  localparam int OCC_W = $clog2(NBUF + 1);

  localparam logic [NBUF-1:0]       SEL0         = {{(NBUF-1){1'b0}}, 1'b1};
  localparam logic [NBUF-1:0]       FLUSH_ALL    = {NBUF{1'b1}};
  localparam logic [NBUF-1:0]       WIN_MASK     = {1'b0, {WIN_SIZE{1'b1}}};
  localparam logic [PTR_W-1:0]      PTR_LAST     = PTR_W'(NBUF - 1);
  localparam logic [OCC_W-1:0]      OCC_FULL     = OCC_W'(NBUF);
  localparam logic [OCC_W-1:0]      OCC_WIN      = OCC_W'(WIN_SIZE);
  localparam logic [LINE_CNT_W-1:0] LINES_ONE    = LINE_CNT_W'(1);
  localparam logic [LINE_CNT_W-1:0] LINES_WIN    = LINE_CNT_W'(WIN_SIZE);
  localparam logic [LINE_CNT_W-1:0] LINES_WIN_M1 = LINE_CNT_W'(WIN_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2
  } state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [PTR_W-1:0]        wr_ptr_r, wr_ptr_nxt_s;
  logic [PTR_W-1:0]        rd_base_r, rd_base_nxt_s;
  logic [OCC_W-1:0]        occ_r, occ_nxt_s;
  logic [LINE_CNT_W-1:0]   wr_lines_r, wr_lines_nxt_s;
  logic [LINE_CNT_W-1:0]   win_cnt_r, win_cnt_nxt_s;
  logic [LINE_CNT_W-1:0]   frame_lines_r, frame_lines_nxt_s;
  logic                    rd_start_r, rd_start_nxt_s;
  logic [NBUF-1:0]         flush_r, flush_nxt_s;
  logic                    frame_done_r, frame_done_nxt_s;

  logic                    wr_stall_s;
  logic                    wr_acc_s;
  logic [2*NBUF-1:0]       win_dbl_s;
  logic [NBUF-1:0]         win_ring_s;
  logic                    win_ok_s;
  logic                    short_s;
  logic                    last_win_s;
  logic [LINE_CNT_W-1:0]   wr_lines_inc_s;

  assign wr_stall_s     = (occ_r == OCC_FULL);
  assign wr_acc_s       = wr_eol_i & ~wr_stall_s & (state_r != IDLE) & (wr_lines_r < frame_lines_r);
  // Rotate the window mask onto the ring so wrap-around windows are handled without a mod
  assign win_dbl_s      = {{NBUF{1'b0}}, WIN_MASK} << rd_base_r;
  assign win_ring_s     = win_dbl_s[NBUF-1:0] | win_dbl_s[2*NBUF-1:NBUF];
  assign win_ok_s       = &(buf_unread_i | ~win_ring_s);
  assign short_s        = (frame_lines_r < LINES_WIN);
  assign last_win_s     = ((win_cnt_r + LINES_ONE) == (frame_lines_r - LINES_WIN_M1));
  assign wr_lines_inc_s = wr_lines_r + LINES_ONE;

  // Next-state and pulse decode; sof_i overrides everything else
  always_comb begin
    state_nxt_s       = state_r;
    wr_ptr_nxt_s      = wr_ptr_r;
    rd_base_nxt_s     = rd_base_r;
    occ_nxt_s         = occ_r;
    wr_lines_nxt_s    = wr_lines_r;
    win_cnt_nxt_s     = win_cnt_r;
    frame_lines_nxt_s = frame_lines_r;
    rd_start_nxt_s    = 1'b0;
    flush_nxt_s       = {NBUF{1'b0}};
    frame_done_nxt_s  = 1'b0;
    if (sof_i) begin
      frame_lines_nxt_s = frame_lines_i;
      wr_ptr_nxt_s      = {PTR_W{1'b0}};
      rd_base_nxt_s     = {PTR_W{1'b0}};
      occ_nxt_s         = {OCC_W{1'b0}};
      wr_lines_nxt_s    = {LINE_CNT_W{1'b0}};
      win_cnt_nxt_s     = {LINE_CNT_W{1'b0}};
      flush_nxt_s       = (state_r != IDLE) ? FLUSH_ALL : {NBUF{1'b0}};
      state_nxt_s       = FILL;
      if (frame_lines_i == {LINE_CNT_W{1'b0}}) begin
        state_nxt_s      = IDLE;
        frame_done_nxt_s = 1'b1;
      end else if (wr_eol_i) begin
        wr_ptr_nxt_s   = ptr_inc({PTR_W{1'b0}});
        occ_nxt_s      = OCC_W'(1);
        wr_lines_nxt_s = LINES_ONE;
        // A one-line frame shorter than the window is complete already
        if ((frame_lines_i < LINES_WIN) && (frame_lines_i == LINES_ONE)) begin
          state_nxt_s      = IDLE;
          flush_nxt_s      = FLUSH_ALL;
          occ_nxt_s        = {OCC_W{1'b0}};
          frame_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s = FILL;
        end
      end else begin
        state_nxt_s = FILL;
      end
    end else begin
      if (wr_acc_s) begin
        wr_ptr_nxt_s   = ptr_inc(wr_ptr_r);
        occ_nxt_s      = occ_r + OCC_W'(1);
        wr_lines_nxt_s = wr_lines_inc_s;
      end else begin
        wr_ptr_nxt_s   = wr_ptr_r;
      end
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        FILL: begin
          if (short_s && wr_acc_s && (wr_lines_inc_s == frame_lines_r)) begin
            state_nxt_s      = IDLE;
            flush_nxt_s      = FLUSH_ALL;
            occ_nxt_s        = {OCC_W{1'b0}};
            frame_done_nxt_s = 1'b1;
          end else if ((occ_r >= OCC_WIN) && win_ok_s) begin
            state_nxt_s    = READ;
            rd_start_nxt_s = 1'b1;
          end else begin
            state_nxt_s = FILL;
          end
        end
        READ: begin
          if (rd_eol_i) begin
            flush_nxt_s   = SEL0 << rd_base_r;
            rd_base_nxt_s = ptr_inc(rd_base_r);
            occ_nxt_s     = wr_acc_s ? occ_r : occ_r - OCC_W'(1);
            win_cnt_nxt_s = win_cnt_r + LINES_ONE;
            if (last_win_s) begin
              state_nxt_s      = IDLE;
              flush_nxt_s      = FLUSH_ALL;
              occ_nxt_s        = {OCC_W{1'b0}};
              frame_done_nxt_s = 1'b1;
            end else begin
              state_nxt_s = FILL;
            end
          end else begin
            state_nxt_s = READ;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State and registered-pulse update with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= IDLE;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_base_r     <= {PTR_W{1'b0}};
      occ_r         <= {OCC_W{1'b0}};
      wr_lines_r    <= {LINE_CNT_W{1'b0}};
      win_cnt_r     <= {LINE_CNT_W{1'b0}};
      frame_lines_r <= {LINE_CNT_W{1'b0}};
      rd_start_r    <= 1'b0;
      flush_r       <= {NBUF{1'b0}};
      frame_done_r  <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_base_r     <= rd_base_nxt_s;
      occ_r         <= occ_nxt_s;
      wr_lines_r    <= wr_lines_nxt_s;
      win_cnt_r     <= win_cnt_nxt_s;
      frame_lines_r <= frame_lines_nxt_s;
      rd_start_r    <= rd_start_nxt_s;
      flush_r       <= flush_nxt_s;
      frame_done_r  <= frame_done_nxt_s;
    end
  end

  assign wr_sel_o     = SEL0 << wr_ptr_r;
  assign wr_stall_o   = wr_stall_s;
  assign rd_base_o    = rd_base_r;
  assign rd_start_o   = rd_start_r;
  assign flush_o      = flush_r;
  assign frame_done_o = frame_done_r;
  assign state_o      = state_r;

endmodule
